// File: rtl/keypad_pkg.sv
// Shared types and row-drive constants for the keypad scanner and decoder.
// Row and column codes are active-low: row0/col0 = 4'b1110 is key "1".
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    localparam logic [3:0] ROW0   = 4'b1110;
    localparam logic [3:0] ROW1   = 4'b1101;
    localparam logic [3:0] ROW2   = 4'b1011;
    localparam logic [3:0] ROW3   = 4'b0111;
    localparam logic [3:0] NO_KEY = 4'b1111;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        logic [3:0] code;
        unique case (idx)
            2'd0: code = ROW0;
            2'd1: code = ROW1;
            2'd2: code = ROW2;
            2'd3: code = ROW3;
            default: code = NO_KEY;
        endcase
        return code;
    endfunction

    // True when exactly one line of an active-low code is asserted.
    function automatic logic one_low(input logic [3:0] code);
        logic [3:0] lo;
        lo = ~code;
        return (lo != 4'b0000) && ((lo & (lo - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/col_synchronizer.sv
// Two-flop synchronizer for the raw keypad column lines.
// Resets to the idle (all pulled-up) code so no key is seen during reset.
module col_synchronizer
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= NO_KEY;
            sync_q <= NO_KEY;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row, debounces a single
// pressed column, and reports the accepted key until its release settles.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DwellW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DebW   = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CNT - 1);
    localparam logic [DebW-1:0]   DebMax    = DebW'(DEBOUNCE_CNT);

    logic [3:0] col_s;

    scan_state_t       state_q, state_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [DebW-1:0]   deb_q, deb_d;
    logic [3:0]        cand_row_q, cand_row_d;
    logic [3:0]        cand_col_q, cand_col_d;
    logic [3:0]        key_row_q, key_row_d;
    logic [3:0]        key_col_q, key_col_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;

    logic [DebW-1:0] deb_inc;
    logic            cand_match;
    logic            latched_high;

    col_synchronizer u_col_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (col),
        .q       (col_s)
    );

    assign deb_inc      = (deb_q == DebMax) ? deb_q : deb_q + DebW'(1);
    assign cand_match   = (col_s == cand_col_q);
    // The accepted key's column line has returned to its pulled-up level.
    assign latched_high = |(col_s & ~key_col_q);

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        dwell_d     = '0;
        deb_d       = deb_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        key_row_d   = key_row_q;
        key_col_d   = key_col_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        unique case (state_q)
            SCAN: begin
                if (dwell_q == DwellLast) begin
                    if (one_low(col_s)) begin
                        cand_row_d = row_drive(row_idx_q);
                        cand_col_d = col_s;
                        deb_d      = '0;
                        state_d    = DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end

            DEBOUNCE: begin
                if (!cand_match) begin
                    deb_d     = '0;
                    row_idx_d = row_idx_q + 2'd1;
                    state_d   = SCAN;
                end else if (deb_q >= DebLast) begin
                    key_row_d   = cand_row_q;
                    key_col_d   = cand_col_q;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    deb_d       = '0;
                    state_d     = HELD;
                end else begin
                    deb_d = deb_inc;
                end
            end

            HELD: begin
                if (latched_high) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (!latched_high) begin
                    deb_d   = '0;
                    state_d = HELD;
                end else if (deb_q >= DebLast) begin
                    key_held_d = 1'b0;
                    deb_d      = '0;
                    row_idx_d  = row_idx_q + 2'd1;
                    state_d    = SCAN;
                end else begin
                    deb_d = deb_inc;
                end
            end

            default: begin
                deb_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            cand_row_q  <= NO_KEY;
            cand_col_q  <= NO_KEY;
            key_row_q   <= NO_KEY;
            key_col_q   <= NO_KEY;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            key_row_q   <= key_row_d;
            key_col_q   <= key_col_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row       = row_drive(row_idx_q);
    assign key_row   = key_row_q;
    assign key_col   = key_col_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioral 4x4 key matrix.
module tb_keypad_scanner;

    logic       clk;
    logic       reset_n;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;  // bit r*4+c = key (row r, col c) is down
    int checks;
    int failures;
    int pulses;
    int consec;
    logic prev_valid;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .col       (col),
        .row       (row),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    // Pulse monitor; sampled on the active edge so it sees the settled value.
    always @(posedge clk) begin
        if (key_valid) begin
            pulses = pulses + 1;
            if (prev_valid) consec = consec + 1;
        end
        prev_valid = key_valid;
    end

    task automatic wait_pulses(input int target);
        int n;
        n = 0;
        while (pulses < target && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_all();
        int n;
        pressed = '0;
        n = 0;
        while (key_held && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (row !== 4'b1110) begin failures++;
            $display("FAIL reset_row: got %b expected 1110", row); end
        checks++; if (key_row !== 4'b1111 || key_col !== 4'b1111) begin failures++;
            $display("FAIL reset_key: got %b/%b expected 1111/1111", key_row, key_col); end
        checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin failures++;
            $display("FAIL reset_flags: got %b%b expected 00", key_valid, key_held); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (row !== 4'b1110) begin failures++;
            $display("FAIL dwell_row0: got %b expected 1110", row); end
        @(negedge clk);
        checks++; if (row !== 4'b1101) begin failures++;
            $display("FAIL dwell_row1: got %b expected 1101", row); end
        repeat (4) @(negedge clk);
        checks++; if (row !== 4'b1011) begin failures++;
            $display("FAIL dwell_row2: got %b expected 1011", row); end
    endtask

    task automatic test_key5();
        int base, n;
        logic row_moved;
        base = pulses;
        pressed[1*4+1] = 1'b1;
        n = 0;
        while (!key_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++; if (key_valid !== 1'b1) begin failures++;
            $display("FAIL key5_pulse: got %b expected 1", key_valid); end
        checks++; if (key_row !== 4'b1101 || key_col !== 4'b1101) begin failures++;
            $display("FAIL key5_code: got %b/%b expected 1101/1101", key_row, key_col); end
        @(negedge clk);
        checks++; if (key_valid !== 1'b0 || key_held !== 1'b1) begin failures++;
            $display("FAIL key5_width: got valid=%b held=%b expected 0/1", key_valid, key_held); end
        row_moved = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (row !== 4'b1101) row_moved = 1'b1;
        end
        checks++; if (row_moved !== 1'b0) begin failures++;
            $display("FAIL key5_row_frozen: got moved=%b expected 0", row_moved); end
        checks++; if (pulses !== base + 1) begin failures++;
            $display("FAIL key5_count: got %0d expected %0d", pulses - base, 1); end
        release_all();
        checks++; if (key_held !== 1'b0 || key_row !== 4'b1101) begin failures++;
            $display("FAIL key5_release: got held=%b row=%b expected 0/1101", key_held, key_row); end
    endtask

    task automatic test_bounce_f();
        int base, n;
        base = pulses;
        n = 0;
        while (row !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
        pressed[3*4+2] = 1'b1;
        n = 0;
        while (row !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
        // Debounce begins four edges after row3 is driven; bounce mid-window.
        repeat (6) @(negedge clk);
        pressed[3*4+2] = 1'b0;
        repeat (2) @(negedge clk);
        pressed[3*4+2] = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (pulses !== base) begin failures++;
            $display("FAIL bounce_no_pulse: got %0d expected 0", pulses - base); end
        checks++; if (key_held !== 1'b0) begin failures++;
            $display("FAIL bounce_no_held: got %b expected 0", key_held); end
        wait_pulses(base + 1);
        repeat (20) @(negedge clk);
        checks++; if (pulses !== base + 1) begin failures++;
            $display("FAIL bounce_count: got %0d expected 1", pulses - base); end
        checks++; if (key_row !== 4'b0111 || key_col !== 4'b1011) begin failures++;
            $display("FAIL bounce_code: got %b/%b expected 0111/1011", key_row, key_col); end
        release_all();
    endtask

    task automatic test_glitch_a();
        int base;
        logic dropped;
        base = pulses;
        pressed[0*4+3] = 1'b1;
        wait_pulses(base + 1);
        @(negedge clk);
        checks++; if (key_row !== 4'b1110 || key_col !== 4'b0111) begin failures++;
            $display("FAIL glitch_code: got %b/%b expected 1110/0111", key_row, key_col); end
        dropped = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) pressed[0*4+3] = 1'b0;
            if (i == 52) pressed[0*4+3] = 1'b1;
            @(negedge clk);
            if (key_held !== 1'b1) dropped = 1'b1;
        end
        checks++; if (dropped !== 1'b0) begin failures++;
            $display("FAIL glitch_held: got dropped=%b expected 0", dropped); end
        checks++; if (pulses !== base + 1) begin failures++;
            $display("FAIL glitch_no_pulse: got %0d expected 1", pulses - base); end
        release_all();
        checks++; if (key_held !== 1'b0) begin failures++;
            $display("FAIL glitch_release: got %b expected 0", key_held); end
        pressed[0*4+3] = 1'b1;
        wait_pulses(base + 2);
        repeat (10) @(negedge clk);
        checks++; if (pulses !== base + 2) begin failures++;
            $display("FAIL glitch_total: got %0d expected 2", pulses - base); end
        release_all();
    endtask

    task automatic test_simultaneous();
        int base;
        logic saw_row3;
        base = pulses;
        pressed[0*4+0] = 1'b1;
        pressed[0*4+2] = 1'b1;
        saw_row3 = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (row === 4'b0111) saw_row3 = 1'b1;
        end
        checks++; if (pulses !== base || key_held !== 1'b0) begin failures++;
            $display("FAIL multi_ignored: got pulses=%0d held=%b expected 0/0",
                     pulses - base, key_held); end
        checks++; if (saw_row3 !== 1'b1) begin failures++;
            $display("FAIL multi_scanning: got saw_row3=%b expected 1", saw_row3); end
        pressed[0*4+2] = 1'b0;
        wait_pulses(base + 1);
        @(negedge clk);
        checks++; if (key_row !== 4'b1110 || key_col !== 4'b1110) begin failures++;
            $display("FAIL multi_key1: got %b/%b expected 1110/1110", key_row, key_col); end
        release_all();
    endtask

    task automatic test_rollover();
        int base;
        base = pulses;
        pressed[0*4+2] = 1'b1;
        wait_pulses(base + 1);
        @(negedge clk);
        checks++; if (key_row !== 4'b1110 || key_col !== 4'b1011) begin failures++;
            $display("FAIL roll_key3: got %b/%b expected 1110/1011", key_row, key_col); end
        pressed[1*4+2] = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (pulses !== base + 1 || key_row !== 4'b1110) begin failures++;
            $display("FAIL roll_ignored: got pulses=%0d row=%b expected 1/1110",
                     pulses - base, key_row); end
        pressed[0*4+2] = 1'b0;
        wait_pulses(base + 2);
        @(negedge clk);
        checks++; if (key_row !== 4'b1101 || key_col !== 4'b1011) begin failures++;
            $display("FAIL roll_key6: got %b/%b expected 1101/1011", key_row, key_col); end
        release_all();
    endtask

    task automatic test_reset_held();
        int base;
        base = pulses;
        pressed[2*4+2] = 1'b1;
        wait_pulses(base + 1);
        repeat (5) @(negedge clk);
        checks++; if (key_held !== 1'b1 || key_row !== 4'b1011) begin failures++;
            $display("FAIL rst9_held: got held=%b row=%b expected 1/1011", key_held, key_row); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (row !== 4'b1110 || key_row !== 4'b1111 || key_col !== 4'b1111) begin
            failures++;
            $display("FAIL rst9_async_codes: got row=%b key=%b/%b expected 1110/1111/1111",
                     row, key_row, key_col); end
        checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin failures++;
            $display("FAIL rst9_async_flags: got %b%b expected 00", key_valid, key_held); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_pulses(base + 2);
        repeat (20) @(negedge clk);
        checks++; if (pulses !== base + 2) begin failures++;
            $display("FAIL rst9_reaccept: got %0d expected 2", pulses - base); end
        checks++; if (key_row !== 4'b1011 || key_col !== 4'b1011 || key_held !== 1'b1) begin
            failures++;
            $display("FAIL rst9_code: got %b/%b held=%b expected 1011/1011/1",
                     key_row, key_col, key_held); end
        release_all();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        pulses     = 0;
        consec     = 0;
        prev_valid = 1'b0;
        pressed    = '0;
        reset_n    = 1'b0;
        test_reset();
        test_key5();
        test_bounce_f();
        test_glitch_a();
        test_simultaneous();
        test_rollover();
        test_reset_held();
        checks++; if (consec !== 0) begin failures++;
            $display("FAIL back_to_back_valid: got %0d expected 0", consec); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives the 4x4 matrix keypad rows and samples its columns. It scans one active-low row at a time, synchronizes and debounces the column inputs, and presents a stable active-low `{row, col}` code to `keypad_decoder`. That code follows the same encoding `keypad_decoder` expects: row0/col0 = `1110` = key "1". It also emits a one-cycle `key_valid` strobe per debounced press. It sits between the keypad pins and the decoder/display logic.

## Interface
- `SCAN_DIV`, default 1000: cycles each row is driven during scanning (≥2).
- `DEBOUNCE_CNT`, default 20000: consecutive stable cycles required to accept a press or a release (≥1).
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `col`  in  4: raw column lines, active-low with pull-ups, asynchronous to `clk`.
- `row`  out  4: row drive, active-low one-hot.
- `key_row`  out  4: latched active-low row code of the accepted key.
- `key_col`  out  4: latched active-low column code of the accepted key.
- `key_valid`  out  1: one-cycle pulse per accepted press.
- `key_held`  out  1: high from acceptance until release is accepted.

## Operation
- `col` passes through a 2-FF synchronizer; all logic below uses the synchronized value `col_s`.
- Row sequence is `1110 → 1101 → 1011 → 0111 → 1110` (row0..row3, wrap).
- **SCAN**
  - Drive the current row for `SCAN_DIV` cycles.
  - On the last dwell cycle, sample `col_s`.
  - If exactly one bit of `col_s` is low: latch the current row and `col_s` into candidate registers, clear the debounce counter, go to DEBOUNCE. `row` stays frozen.
  - Otherwise (`1111`, or two or more bits low): advance to the next row and stay in SCAN.
- **DEBOUNCE**
  - Each cycle `col_s` equals the candidate column, increment the counter.
  - Any mismatch: go to SCAN, advance to the next row, no outputs change.
  - When the counter reaches `DEBOUNCE_CNT`: copy the candidate to `key_row`/`key_col`, pulse `key_valid`, set `key_held`, go to HELD.
- **HELD**
  - `row` stays frozen.
  - Other key presses are ignored (no rollover).
  - When the latched column bit of `col_s` reads high: clear the counter, go to RELEASE.
- **RELEASE**
  - Each cycle the latched column bit is high, increment the counter.
  - If the bit reads low: return to HELD with no new pulse.
  - When the counter reaches `DEBOUNCE_CNT`: clear `key_held`, go to SCAN, advance to the next row.
- `key_row`/`key_col` keep the last accepted key until the next acceptance.
- Counters saturate and are cleared on every state entry.

## Timing
- Reset values:
  - state SCAN, row index 0, so `row = 1110`
  - dwell and debounce counters 0, synchronizer flops `1111`
  - `key_row = 1111`, `key_col = 1111`, `key_valid = 0`, `key_held = 0`
- Reset asserted in any state returns every output to its reset value immediately and asynchronously. After deassertion, scanning restarts at row0.
- Input latency: a change on `col` is visible on `col_s` 2 cycles later.
- Press latency: the first matching DEBOUNCE cycle follows the sample cycle. `key_valid` is registered and goes high in the cycle after the `DEBOUNCE_CNT`-th consecutive match.
  - `key_row`/`key_col`/`key_held` update on that same edge.
- `key_valid` is high for exactly 1 cycle per accepted press, never in consecutive cycles.
- Release latency: `key_held` falls in the cycle after the `DEBOUNCE_CNT`-th consecutive high sample. The next row is driven on that same edge.
- A key already held at reset release is accepted normally on its first scan.

## Structure
- Package `keypad_pkg`:
  - `scan_state_t` enum: SCAN, DEBOUNCE, HELD, RELEASE.
  - Row-drive constants `ROW0..ROW3` and `NO_KEY = 4'b1111`.
  - Shared with `keypad_decoder` and the top level.
- Sub-module `col_synchronizer`: 4-bit 2-FF synchronizer, reset to `1111`.
- Remainder is one FSM with a row-index register, a dwell counter and a debounce counter.

## Test plan
Bench parameters: `SCAN_DIV=4`, `DEBOUNCE_CNT=8`. A behavioral keypad model pulls `col[c]` low when `row[r]` is low and key (r,c) is pressed.
- Reset mid-HELD with key "9" pressed → outputs return immediately to `row=1110`, `key_row=key_col=1111`, `key_valid=0`, `key_held=0`. After release of reset the key is re-accepted with one new pulse.
- Press key "5" (row1/col1) held steady → one `key_valid` pulse with `key_row=1101`, `key_col=1101`. `row` stays `1101` while held.
- Press "F" (row3/col2) bouncing 3 cycles into debounce, then stable → no pulse at the bounce. Exactly one pulse later with `key_row=0111`, `key_col=1011`.
- Hold "A" for 100 cycles with a 2-cycle release glitch, then release and press "A" again → glitch produces no pulse and `key_held` stays high. Exactly 2 pulses total.
- Press keys (row0,col0) and (row0,col2) simultaneously → no acceptance and rows keep cycling. After (row0,col2) is released, key "1" is accepted.
- Press "3", then press "6" while "3" is held → "6" ignored. After "3" is released, "6" is accepted with `key_row=1101`, `key_col=1011`.
